// File: rtl/key_menu_pkg.sv
// Shared types and constants for the key menu controller.
// Covers the FSM states, the mode/gate encodings, the key indices and the lowest-key priority select.
package key_menu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } menu_state_t;

    typedef enum logic [1:0] {
        MODE_FREQ     = 2'd0,
        MODE_PERIOD   = 2'd1,
        MODE_DUTY     = 2'd2,
        MODE_INTERVAL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        GATE_10MS  = 2'd0,
        GATE_100MS = 2'd1,
        GATE_1S    = 2'd2,
        GATE_10S   = 2'd3
    } gate_t;

    localparam logic [1:0] K_MODE = 2'd0;
    localparam logic [1:0] K_GATE = 2'd1;
    localparam logic [1:0] K_UP   = 2'd2;
    localparam logic [1:0] K_DN   = 2'd3;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } key_sel_t;

    // Lowest set index wins when several keys are active together.
    function automatic key_sel_t lowest_key(input logic [3:0] v);
        key_sel_t r;
        r.vld = |v;
        r.idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r.idx = i[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/key_menu_ctrl_ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_FREQ/TICK_HZ clocks.
// Implemented as a down-counter; the tick is the terminal count.
module ms_tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/key_menu_ctrl.sv
// Turns debounced key status into mode, gate time and trigger threshold settings.
// Step keys auto-repeat after a long press and accelerate after FAST_CNT repeats.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no step key active; mode/gate/step presses are accepted
//   ST_HOLD   | step key held, counting ms toward the first auto-repeat
//   ST_REPEAT | auto-repeating every REP_MS ms, rep_active high
module key_menu_ctrl
    import key_menu_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int HOLD_MS   = 500,
    parameter int REP_MS    = 100,
    parameter int FAST_CNT  = 8,
    parameter int FAST_STEP = 16,
    parameter int THR_W     = 12,
    parameter int THR_MIN   = 0,
    parameter int THR_MAX   = 4095,
    parameter int THR_DEF   = 2048
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [3:0]       sta_key,
    input  logic [3:0]       sta_key_pos,
    output logic [1:0]       mode,
    output logic [1:0]       gate_sel,
    output logic [THR_W-1:0] thresh,
    output logic             cfg_upd,
    output logic             rep_active
);

    localparam int HC_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
    localparam int RC_W = (REP_MS > 1) ? $clog2(REP_MS) : 1;
    localparam int RN_W = $clog2(FAST_CNT + 1);

    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_MS - 1);
    localparam logic [RC_W-1:0]  REP_LAST  = RC_W'(REP_MS - 1);
    localparam logic [RN_W-1:0]  RN_SAT    = RN_W'(FAST_CNT);
    localparam logic [THR_W:0]   STEP_ONE  = (THR_W+1)'(1);
    localparam logic [THR_W:0]   STEP_FAST = (THR_W+1)'(FAST_STEP);
    localparam logic [THR_W:0]   LIM_MIN   = (THR_W+1)'(THR_MIN);
    localparam logic [THR_W:0]   LIM_MAX   = (THR_W+1)'(THR_MAX);

    logic tick;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (1000)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    menu_state_t      state_q, state_d;
    logic             dir_q, dir_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [RC_W-1:0]  msc_q, msc_d;
    logic [RN_W-1:0]  repn_q, repn_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       gate_q, gate_d;
    logic [THR_W-1:0] thr_q, thr_d;
    logic             upd_q, upd_d;

    key_sel_t   pos_sel, lvl_sel;
    logic [1:0] dir_key;
    logic       held;
    logic       step_req, step_dn, step_big;
    logic [THR_W:0]   step_amt, thr_ext, step_sum;
    logic [THR_W-1:0] thr_step;

    assign pos_sel = lowest_key(sta_key_pos);
    assign lvl_sel = lowest_key(sta_key);
    assign dir_key = dir_q ? K_DN : K_UP;
    assign held    = lvl_sel.vld && (lvl_sel.idx == dir_key);

    // Saturating step: one extra bit exposes the borrow/carry before clamping.
    always_comb begin
        step_amt = step_big ? STEP_FAST : STEP_ONE;
        thr_ext  = {1'b0, thr_q};
        step_sum = '0;
        thr_step = thr_q;
        if (step_dn) begin
            step_sum = thr_ext - step_amt;
            if (step_sum[THR_W] || step_sum < LIM_MIN) thr_step = LIM_MIN[THR_W-1:0];
            else                                       thr_step = step_sum[THR_W-1:0];
        end else begin
            step_sum = thr_ext + step_amt;
            if (step_sum > LIM_MAX) thr_step = LIM_MAX[THR_W-1:0];
            else                    thr_step = step_sum[THR_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        msc_d    = msc_q;
        repn_d   = repn_q;
        mode_d   = mode_q;
        gate_d   = gate_q;
        step_req = 1'b0;
        step_dn  = dir_q;
        step_big = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pos_sel.vld) begin
                    case (pos_sel.idx)
                        K_MODE: mode_d = mode_q + 2'd1;
                        K_GATE: gate_d = gate_q + 2'd1;
                        default: begin
                            step_req = 1'b1;
                            step_dn  = (pos_sel.idx == K_DN);
                            dir_d    = (pos_sel.idx == K_DN);
                            hold_d   = '0;
                            state_d  = ST_HOLD;
                        end
                    endcase
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (pos_sel.vld && pos_sel.idx == dir_key) begin
                    step_req = 1'b1;
                    hold_d   = '0;
                    state_d  = ST_HOLD;
                end else if (!held) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (state_q == ST_HOLD) begin
                        if (hold_q == HOLD_LAST) begin
                            step_req = 1'b1;
                            repn_d   = RN_W'(1);
                            msc_d    = '0;
                            state_d  = ST_REPEAT;
                        end else begin
                            hold_d = hold_q + HC_W'(1);
                        end
                    end else if (msc_q == REP_LAST) begin
                        msc_d    = '0;
                        step_req = 1'b1;
                        step_big = (repn_q >= RN_SAT);
                        if (repn_q < RN_SAT) repn_d = repn_q + RN_W'(1);
                    end else begin
                        msc_d = msc_q + RC_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        thr_d = step_req ? thr_step : thr_q;
        upd_d = (mode_d != mode_q) || (gate_d != gate_q) || (thr_d != thr_q);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            hold_q  <= '0;
            msc_q   <= '0;
            repn_q  <= '0;
            mode_q  <= MODE_FREQ;
            gate_q  <= GATE_1S;
            thr_q   <= THR_W'(THR_DEF);
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            msc_q   <= msc_d;
            repn_q  <= repn_d;
            mode_q  <= mode_d;
            gate_q  <= gate_d;
            thr_q   <= thr_d;
            upd_q   <= upd_d;
        end
    end

    assign mode       = mode_q;
    assign gate_sel   = gate_q;
    assign thresh     = thr_q;
    assign cfg_upd    = upd_q;
    assign rep_active = (state_q == ST_REPEAT);

endmodule
